// File: rtl/flash_loader_pkg.sv
// Shared state encoding and default copy-window constants for the flash-to-SDRAM boot loader.
package flash_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        NEXT,
        DONE
    } state_t;

    localparam logic [21:0] FLASH_BASE_DEF = 22'h100000;
    localparam logic [21:0] RAM_BASE_DEF   = 22'h0fc000;
    localparam logic [21:0] WORDS_DEF      = 22'd16000;

endpackage

// File: rtl/flash_loader.sv
// Boot-time copier: streams WORDS flash words into SDRAM, then raises done to release the Atari reset.
// Optional FLASH_LOADER_BUSY_EN: end each flash read on the falling edge of flash_busy, with a 4*FLASH_WAIT timeout.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter logic [21:0] FLASH_BASE = FLASH_BASE_DEF,
    parameter logic [21:0] RAM_BASE   = RAM_BASE_DEF,
    parameter logic [21:0] WORDS      = WORDS_DEF,
    parameter logic [5:0]  FLASH_WAIT = 6'd9,
    parameter logic [2:0]  WRITE_LEN  = 3'd5
) (
    input  logic        clk32,
    input  logic        resb,
    input  logic        start,
    output logic [21:0] flash_addr,
    output logic        flash_cs,
    input  logic        flash_busy,
    input  logic [15:0] flash_dout,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        done
);

    // The REQ cycle counts as the first access cycle, so WAIT starts one below the full count.
`ifdef FLASH_LOADER_BUSY_EN
    localparam logic [7:0] WAIT_LOAD = {FLASH_WAIT, 2'b00} - 8'd1;
`else
    localparam logic [7:0] WAIT_LOAD = {2'b00, FLASH_WAIT} - 8'd1;
`endif

    state_t      state, state_nx;
    logic [21:0] flash_addr_nx, ram_addr_nx, words_left, words_left_nx;
    logic [15:0] ram_din_nx;
    logic        flash_cs_nx;
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic [2:0]  wr_cnt, wr_cnt_nx;
    logic        start_d;
    logic        start_rise;
    logic        wait_exit;

    assign start_rise = start && !start_d;

`ifdef FLASH_LOADER_BUSY_EN
    logic busy_d;

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) busy_d <= 1'b0;
        else       busy_d <= flash_busy;
    end

    assign wait_exit = (busy_d && !flash_busy) || (wait_cnt == 8'd1);
`else
    assign wait_exit = (wait_cnt == 8'd1);
`endif

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state      <= IDLE;
            flash_addr <= FLASH_BASE;
            ram_addr   <= RAM_BASE;
            words_left <= WORDS;
            ram_din    <= '0;
            flash_cs   <= 1'b0;
            wait_cnt   <= '0;
            wr_cnt     <= '0;
            start_d    <= 1'b0;
        end else begin
            state      <= state_nx;
            flash_addr <= flash_addr_nx;
            ram_addr   <= ram_addr_nx;
            words_left <= words_left_nx;
            ram_din    <= ram_din_nx;
            flash_cs   <= flash_cs_nx;
            wait_cnt   <= wait_cnt_nx;
            wr_cnt     <= wr_cnt_nx;
            start_d    <= start;
        end
    end

    always_comb begin
        state_nx      = state;
        flash_addr_nx = flash_addr;
        ram_addr_nx   = ram_addr;
        words_left_nx = words_left;
        ram_din_nx    = ram_din;
        wait_cnt_nx   = wait_cnt;
        wr_cnt_nx     = wr_cnt;

        case (state)
            IDLE: begin
                if (start_rise) state_nx = (WORDS == '0) ? DONE : REQ;
            end
            REQ: begin
                wait_cnt_nx = WAIT_LOAD;
                state_nx    = WAIT;
            end
            WAIT: begin
                wait_cnt_nx = wait_cnt - 8'd1;
                if (wait_exit) begin
                    ram_din_nx    = flash_dout;
                    flash_addr_nx = flash_addr + 22'd1;
                    words_left_nx = words_left - 22'd1;
                    wr_cnt_nx     = WRITE_LEN;
                    state_nx      = WRITE;
                end
            end
            WRITE: begin
                wr_cnt_nx = wr_cnt - 3'd1;
                if (wr_cnt == 3'd1) state_nx = NEXT;
            end
            NEXT: begin
                ram_addr_nx = ram_addr + 22'd1;
                state_nx    = (words_left == '0) ? DONE : REQ;
            end
            DONE: ;
            default: state_nx = IDLE;
        endcase

        // Losing "memories ready" abandons the copy and rearms for a fresh start edge.
        if (state != IDLE && !start) begin
            state_nx      = IDLE;
            flash_addr_nx = FLASH_BASE;
            ram_addr_nx   = RAM_BASE;
            words_left_nx = WORDS;
        end

        flash_cs_nx = flash_cs;
        if (state_nx == REQ)                                     flash_cs_nx = 1'b1;
        else if (flash_busy || state_nx == DONE || state_nx == IDLE) flash_cs_nx = 1'b0;
    end

    assign ram_cs = (state == WRITE);
    assign ram_we = (state == WRITE);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader: copy timing, abort/restart, async reset, WORDS=0 and address wrap.
module tb_flash_loader;

    logic        clk32, resb, start, flash_busy;
    logic [21:0] flash_addr, ram_addr;
    logic [15:0] flash_dout, ram_din;
    logic        flash_cs, ram_cs, ram_we, done;

    logic        start_z;
    logic [21:0] flash_addr_z, ram_addr_z, flash_addr_w, ram_addr_w;
    logic [15:0] flash_dout_z, ram_din_z, flash_dout_w, ram_din_w;
    logic        flash_cs_z, ram_cs_z, ram_we_z, done_z;
    logic        flash_cs_w, ram_cs_w, ram_we_w, done_w;

    int n_checks = 0;
    int n_pass   = 0;
    int z_strobes = 0;
    logic [21:0] waddr_q[$];
    logic [15:0] wdata_q[$];

    assign flash_dout   = flash_addr[15:0];
    assign flash_dout_z = flash_addr_z[15:0];
    assign flash_dout_w = flash_addr_w[15:0];

    flash_loader #(.FLASH_BASE(22'h100000), .RAM_BASE(22'h0fc000), .WORDS(22'd4),
                   .FLASH_WAIT(6'd9), .WRITE_LEN(3'd5)) dut (
        .clk32(clk32), .resb(resb), .start(start),
        .flash_addr(flash_addr), .flash_cs(flash_cs), .flash_busy(flash_busy), .flash_dout(flash_dout),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_cs(ram_cs), .ram_we(ram_we), .done(done));

    flash_loader #(.WORDS(22'd0)) u_zero (
        .clk32(clk32), .resb(resb), .start(start_z),
        .flash_addr(flash_addr_z), .flash_cs(flash_cs_z), .flash_busy(1'b0), .flash_dout(flash_dout_z),
        .ram_addr(ram_addr_z), .ram_din(ram_din_z), .ram_cs(ram_cs_z), .ram_we(ram_we_z), .done(done_z));

    flash_loader #(.FLASH_BASE(22'h3fffff), .RAM_BASE(22'h3fffff), .WORDS(22'd2),
                   .FLASH_WAIT(6'd2), .WRITE_LEN(3'd1)) u_wrap (
        .clk32(clk32), .resb(resb), .start(start_z),
        .flash_addr(flash_addr_w), .flash_cs(flash_cs_w), .flash_busy(1'b0), .flash_dout(flash_dout_w),
        .ram_addr(ram_addr_w), .ram_din(ram_din_w), .ram_cs(ram_cs_w), .ram_we(ram_we_w), .done(done_w));

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    always @(negedge clk32) begin
        if (ram_cs_z || ram_we_z || flash_cs_z) z_strobes++;
        if (ram_cs_w) begin
            waddr_q.push_back(ram_addr_w);
            wdata_q.push_back(ram_din_w);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // c counts edges from REQ entry of word 0; each word is REQ(1)+WAIT(8)+WRITE(5)+NEXT(1).
    task automatic copy_run(input int stop_c, input bit use_reset);
        for (int c = 0; c <= 64; c++) begin
            int   w;
            int   p;
            logic wr;
            @(posedge clk32); #1;
            w  = c / 15;
            p  = c % 15;
            wr = (c < 60) && (p >= 9) && (p <= 13);
            check("ram_cs", ram_cs, wr);
            check("ram_we", ram_we, wr);
            if (wr) begin
                check("ram_addr", ram_addr, 22'h0fc000 + w);
                check("ram_din", ram_din, w);
            end
            check("done", done, c >= 60);
            if (c == 2 || c == 16 || c == 24) check("flash_cs_hi", flash_cs, 1);
            if (c == 3 || c == 60)            check("flash_cs_lo", flash_cs, 0);
            if (c == 23) begin
                check("latch_w0_din", ram_din, 16'h0000);
                check("latch_w0_fa", flash_addr, 22'h100001);
            end
            if (c == 24) begin
                check("latch_w1_din", ram_din, 16'h0001);
                check("latch_w1_fa", flash_addr, 22'h100002);
            end
            if (c == 2) flash_busy = 1'b1;
            if (c == 3) flash_busy = 1'b0;
            if (c == stop_c) begin
                if (use_reset) begin
                    #2 resb = 1'b0;
                    #1;
                    check("arst_ram_cs", ram_cs, 0);
                    check("arst_ram_we", ram_we, 0);
                    check("arst_flash_cs", flash_cs, 0);
                    check("arst_fa", flash_addr, 22'h100000);
                end else begin
                    start = 1'b0;
                    @(posedge clk32); #1;
                    check("abort_done", done, 0);
                    check("abort_fa", flash_addr, 22'h100000);
                    check("abort_ra", ram_addr, 22'h0fc000);
                    check("abort_ram_cs", ram_cs, 0);
                    check("abort_flash_cs", flash_cs, 0);
                end
                return;
            end
        end
    endtask

    task automatic busy_run();
        start = 1'b1;
        for (int c = 0; c <= 45; c++) begin
            @(posedge clk32); #1;
            if (c == 2) check("bfall_pre_cs", ram_cs, 0);
            if (c == 3) begin
                check("bfall_cs", ram_cs, 1);
                check("bfall_fa", flash_addr, 22'h100001);
            end
            if (c == 44) check("btmo_pre_cs", ram_cs, 0);
            if (c == 45) begin
                check("btmo_cs", ram_cs, 1);
                check("btmo_din", ram_din, 16'h0001);
                check("btmo_fa", flash_addr, 22'h100002);
            end
            if (c == 0) flash_busy = 1'b1;
            if (c == 2) flash_busy = 1'b0;
            if (c == 3) flash_busy = 1'b1;
        end
        flash_busy = 1'b0;
        start = 1'b0;
        @(posedge clk32); #1;
        check("babort_fa", flash_addr, 22'h100000);
    endtask

    initial begin
        int done_c;
        resb = 1'b0; start = 1'b0; start_z = 1'b0; flash_busy = 1'b0;
        repeat (3) @(posedge clk32);
        #1;
        check("rst_fa", flash_addr, 22'h100000);
        check("rst_ra", ram_addr, 22'h0fc000);
        check("rst_din", ram_din, 16'h0000);
        check("rst_flash_cs", flash_cs, 0);
        check("rst_ram_cs", ram_cs, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_done", done, 0);
        check("rst_wrap_fa", flash_addr_w, 22'h3fffff);
        @(posedge clk32); #2 resb = 1'b1;
        @(posedge clk32); #1;
        check("idle_done", done, 0);
        check("idle_flash_cs", flash_cs, 0);

`ifdef FLASH_LOADER_BUSY_EN
        busy_run();
`else
        start = 1'b1;
        copy_run(-1, 1'b0);
        start = 1'b0;
        @(posedge clk32); #1;
        check("drop_done", done, 0);
        check("drop_fa", flash_addr, 22'h100000);
        check("drop_ra", ram_addr, 22'h0fc000);
        start = 1'b1;
        copy_run(33, 1'b0);
        start = 1'b1;
        copy_run(-1, 1'b0);
        start = 1'b0;
        @(posedge clk32); #1;
        start = 1'b1;
        copy_run(24, 1'b1);
        @(posedge clk32); #1;
        check("inrst_din", ram_din, 16'h0000);
        check("inrst_ra", ram_addr, 22'h0fc000);
        resb = 1'b1;
        copy_run(-1, 1'b0);
`endif

        check("z_pre_done", done_z, 0);
        start_z = 1'b1;
        done_c = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk32); #1;
            if (c == 0) check("z_done", done_z, 1);
            if (done_w && done_c < 0) done_c = c;
        end
`ifdef FLASH_LOADER_BUSY_EN
        check("wrap_done_c", done_c, 20);
`else
        check("wrap_done_c", done_c, 8);
`endif
        check("z_strobes", z_strobes, 0);
        check("z_done_sticky", done_z, 1);
        check("wrap_fa", flash_addr_w, 22'h000001);
        check("wrap_ra", ram_addr_w, 22'h000001);
        check("wrap_nwr", waddr_q.size(), 2);
        if (waddr_q.size() == 2) begin
            check("wrap_a0", waddr_q[0], 22'h3fffff);
            check("wrap_a1", waddr_q[1], 22'h000000);
            check("wrap_d0", wdata_q[0], 16'hffff);
            check("wrap_d1", wdata_q[1], 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
